// File: rtl/bus_receiver_pkg.sv
// rtl/bus_receiver_pkg.sv - shared byte-bus frame layout constants and receiver state encoding
// Frame layout is {addr, data} sent MSB byte first; the arbiter uses the same constants.
package bus_receiver_pkg;

  localparam int BUS_ADDRW   = 24;
  localparam int BUS_FRAME_W = BUS_ADDRW + 8;
  localparam int BUS_NBYTES  = BUS_FRAME_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  function automatic int frame_beats(input int addrw);
    return (addrw + 8) / 8;
  endfunction

endpackage

// File: rtl/bus_rx_timer.sv
// rtl/bus_rx_timer.sv - saturating idle counter with clear/enable and an expired flag
// expired is high while the count sits at TIMEOUT-1; the caller decides what expiry means.
module bus_rx_timer
  import bus_receiver_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idle_cnt <= '0;
    end else if (enable && idle_cnt != LAST) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  assign expired = (idle_cnt == LAST);

endmodule

// File: rtl/bus_receiver.sv
// rtl/bus_receiver.sv - reassembles byte-bus beats into {addr, data} frames behind a one-entry output register
// Truncated frames are dropped after TIMEOUT idle cycles and flagged on frame_err.
module bus_receiver
  import bus_receiver_pkg::*;
#(
  parameter int ADDRW   = BUS_ADDRW,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  output logic             bus_ready,
  output logic [ADDRW-1:0] addr_out,
  output logic [7:0]       data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             busy
);

  localparam int NBYTES = frame_beats(ADDRW);
  localparam int BW     = (NBYTES > 2) ? $clog2(NBYTES) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBYTES - 1);

  rx_state_e        state;
  logic [BW-1:0]    beat_cnt;
  logic [ADDRW-1:0] shreg;
  logic             beat;
  logic             idle_tick;
  logic             expired;
  logic             timeout;

  // Only the final beat can stall, and only while the output register is full and not draining.
  assign bus_ready = !((beat_cnt == LAST_BEAT) && out_valid && !out_ready);
  assign beat      = valid_in && bus_ready;
  assign idle_tick = (state == RECV) && !valid_in && bus_ready;
  assign timeout   = idle_tick && expired;
  assign busy      = (state == RECV);

  bus_rx_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state != RECV) || beat),
    .enable  (idle_tick),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      shreg     <= '0;
      addr_out  <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (beat) begin
            shreg    <= ADDRW'({shreg, data_in});
            beat_cnt <= BW'(1);
            state    <= RECV;
          end
        end
        RECV: begin
          if (beat) begin
            if (beat_cnt == LAST_BEAT) begin
              // A load overrides the consume clear above.
              addr_out  <= shreg;
              data_out  <= data_in;
              out_valid <= 1'b1;
              beat_cnt  <= '0;
              state     <= IDLE;
            end else begin
              shreg    <= ADDRW'({shreg, data_in});
              beat_cnt <= beat_cnt + BW'(1);
            end
          end else if (timeout) begin
            beat_cnt  <= '0;
            state     <= IDLE;
            frame_err <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_receiver.sv
// tb/tb_bus_receiver.sv - directed self-checking bench for bus_receiver (ADDRW=24, TIMEOUT=16)
module tb_bus_receiver;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        bus_ready;
  logic [23:0] addr_out;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bus_receiver #(
    .ADDRW   (24),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .bus_ready (bus_ready),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the byte on the bus until it is accepted (bounded), then returns 1 ns after that edge.
  task automatic send_beat(input logic [7:0] b);
    int n;
    valid_in = 1'b1;
    data_in  = b;
    n = 0;
    while (!bus_ready && n < 40) begin
      tick();
      n++;
    end
    check("beat_accept_ready", {31'b0, bus_ready}, 32'd1);
    tick();
  endtask

  task automatic check_frame(input string tag, input logic [23:0] a, input logic [7:0] d);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_addr"}, {8'b0, addr_out}, {8'b0, a});
    check({tag, "_data"}, {24'b0, data_out}, {24'b0, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2 [8];
    int n_err;
    logic err16, busy15;

    rst = 1'b1; data_in = 8'h00; valid_in = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_bus_ready", {31'b0, bus_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_addr", {8'b0, addr_out}, 32'd0);
    check("rst_data", {24'b0, data_out}, 32'd0);
    rst = 1'b0;

    // 1. basic frame
    out_ready = 1'b1;
    send_beat(8'h12); send_beat(8'h34); send_beat(8'h56); send_beat(8'h78);
    valid_in = 1'b0;
    check_frame("t1", 24'h123456, 8'h78);
    check("t1_busy_after", {31'b0, busy}, 32'd0);
    tick();
    check("t1_valid_one_cycle", {31'b0, out_valid}, 32'd0);

    // 2. back to back frames
    t2[0] = 8'hAA; t2[1] = 8'hBB; t2[2] = 8'hCC; t2[3] = 8'h01;
    t2[4] = 8'h00; t2[5] = 8'h00; t2[6] = 8'h10; t2[7] = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check("t2_bus_ready", {31'b0, bus_ready}, 32'd1);
      send_beat(t2[i]);
      if (i == 3) check_frame("t2_f1", 24'hAABBCC, 8'h01);
      if (i == 4) check("t2_gap_valid", {31'b0, out_valid}, 32'd0);
    end
    valid_in = 1'b0;
    check_frame("t2_f2", 24'h000010, 8'hFF);
    tick();

    // 3. output backpressure
    out_ready = 1'b0;
    send_beat(8'h11); send_beat(8'h22); send_beat(8'h33); send_beat(8'h44);
    check_frame("t3_f1", 24'h112233, 8'h44);
    check("t3_b0_ready", {31'b0, bus_ready}, 32'd1);
    send_beat(8'h55);
    check("t3_b1_ready", {31'b0, bus_ready}, 32'd1);
    send_beat(8'h66);
    check("t3_b2_ready", {31'b0, bus_ready}, 32'd1);
    send_beat(8'h77);
    valid_in = 1'b1; data_in = 8'h88;
    #1;
    check("t3_b3_stall", {31'b0, bus_ready}, 32'd0);
    tick(); tick();
    check("t3_stall_hold", {31'b0, bus_ready}, 32'd0);
    check_frame("t3_f1_hold", 24'h112233, 8'h44);
    check("t3_busy_stall", {31'b0, busy}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("t3_release_ready", {31'b0, bus_ready}, 32'd1);
    tick();
    valid_in = 1'b0;
    check_frame("t3_f2", 24'h556677, 8'h88);
    tick();
    check("t3_drained", {31'b0, out_valid}, 32'd0);

    // 4. timeout after two beats and 16 idle cycles
    send_beat(8'h01); send_beat(8'h02);
    valid_in = 1'b0;
    n_err = 0; err16 = 1'b0; busy15 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (frame_err) n_err++;
      if (i == 15) busy15 = busy;
      if (i == 16) err16 = frame_err;
    end
    check("t4_busy_before", {31'b0, busy15}, 32'd1);
    check("t4_err_at16", {31'b0, err16}, 32'd1);
    check("t4_err_count", n_err, 32'd1);
    check("t4_busy_after", {31'b0, busy}, 32'd0);
    check("t4_out_untouched", {31'b0, out_valid}, 32'd0);
    send_beat(8'hDE); send_beat(8'hAD); send_beat(8'hBE); send_beat(8'hEF);
    valid_in = 1'b0;
    check_frame("t4", 24'hDEADBE, 8'hEF);
    tick();

    // 5. timeout boundary: beat arrives on the 16th cycle
    send_beat(8'h01); send_beat(8'h02);
    valid_in = 1'b0;
    n_err = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (frame_err) n_err++;
    end
    send_beat(8'h03);
    if (frame_err) n_err++;
    check("t5_busy", {31'b0, busy}, 32'd1);
    send_beat(8'h04);
    valid_in = 1'b0;
    check("t5_no_err", n_err, 32'd0);
    check_frame("t5", 24'h010203, 8'h04);
    tick();

    // 6. reset mid-frame with a pending output
    out_ready = 1'b0;
    send_beat(8'hA1); send_beat(8'hB2); send_beat(8'hC3); send_beat(8'hD4);
    send_beat(8'hE5); send_beat(8'hF6);
    valid_in = 1'b0;
    check("t6_pending", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid", {31'b0, out_valid}, 32'd0);
    check("t6_ready", {31'b0, bus_ready}, 32'd1);
    check("t6_busy", {31'b0, busy}, 32'd0);
    out_ready = 1'b1;
    send_beat(8'h9A); send_beat(8'hBC); send_beat(8'hDE); send_beat(8'hF0);
    valid_in = 1'b0;
    check_frame("t6", 24'h9ABCDE, 8'hF0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
